instr_fetch_unit: RTL and testbench

- Producer side of the instruction-register interface: fetches 32-bit instruction words from a synchronous instruction memory and presents them to the IR/ALU stage over a valid/ready handshake.
- Owns the program counter, absorbs consumer backpressure with a 2-entry buffer, honours jump redirects, and stops on a HALT opcode.
- Sits between instruction memory and the IR load point of the execute stage.

---
 rtl/ifu_pkg.sv | 32 +++
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/ifu_buf2.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Instruction-word layout and opcodes shared by the fetch unit and the IR/ALU stage.
package ifu_pkg;

    localparam int unsigned OPER_TYPE_MSB = 31;
    localparam int unsigned OPER_TYPE_LSB = 27;
    localparam int unsigned RDST_MSB      = 26;
    localparam int unsigned RDST_LSB      = 22;
    localparam int unsigned RSRC1_MSB     = 21;
    localparam int unsigned RSRC1_LSB     = 17;
    localparam int unsigned MODE_BIT      = 16;
    localparam int unsigned RSRC2_MSB     = 15;
    localparam int unsigned RSRC2_LSB     = 11;
    localparam int unsigned ISRC_MSB      = 15;
    localparam int unsigned ISRC_LSB      = 0;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_MOV  = 5'd1;
    localparam opcode_t OP_ADD  = 5'd2;
    localparam opcode_t OP_HALT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALTED
    } ifu_state_t;

    function automatic opcode_t oper_type(input logic [31:0] word);
        return word[OPER_TYPE_MSB:OPER_TYPE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port, IR valid/ready stream and jump redirect.
interface instr_fetch_unit_if #(
    parameter int unsigned AW = 8
);
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   ir_out;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          redirect_en;
    logic [AW-1:0] redirect_addr;

    modport master (
        output imem_en, imem_addr, ir_out, ir_pc, ir_valid,
        input  imem_rdata, ir_ready, redirect_en, redirect_addr
    );

    modport slave (
        input  imem_en, imem_addr, ir_out, ir_pc, ir_valid,
        output imem_rdata, ir_ready, redirect_en, redirect_addr
    );
endinterface

// File: rtl/ifu_buf2.sv
// Two-entry {pc, word} FIFO between memory read data and the IR stream; flush beats push.
module ifu_buf2 #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [AW-1:0] push_pc,
    input  logic [31:0]   push_word,
    output logic [AW-1:0] head_pc,
    output logic [31:0]   head_word,
    output logic [1:0]    count
);
    logic [AW-1:0] pc_q   [2];
    logic [31:0]   word_q [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= '0;
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
            word_q[0] <= '0;
            word_q[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]   <= push_pc;
                word_q[wr_ptr] <= push_word;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_pc   = pc_q[rd_ptr];
    assign head_word = word_q[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, synchronous-memory reads, 2-deep IR buffer, redirect and HALT.
// Optional macro IFU_PERF_EN adds saturating perf_issued / perf_stall counters.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    instr_fetch_unit_if.master bus,
    output logic               halted
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall
`endif
);
    ifu_state_t    state;
    ifu_state_t    state_nx;
    logic [AW-1:0] pc;
    logic [AW-1:0] inflight_pc;
    logic          inflight;
    logic [AW-1:0] head_pc;
    logic [31:0]   head_word;
    logic [1:0]    count;
    logic [2:0]    occupancy;
    logic          valid;
    logic          xfer;
    logic          redirect;
    logic          halt_xfer;
    logic          flush;
    logic          issue;

    assign valid     = (count != 2'd0);
    assign xfer      = valid && bus.ir_ready;
    assign occupancy = {1'b0, count} + {2'b0, inflight};
    assign flush     = redirect || halt_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        redirect  = 1'b0;
        halt_xfer = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                redirect  = bus.redirect_en;
                halt_xfer = xfer && (oper_type(head_word) == OP_HALT) && !bus.redirect_en;
                if (halt_xfer) state_nx = ST_HALTED;
                // A head leaving this cycle frees its slot, keeping one read per cycle under ready.
                issue = !redirect && !halt_xfer && (occupancy < (3'd2 + {2'b0, xfer}));
            end
            ST_HALTED: begin
                if (bus.redirect_en) begin
                    redirect = 1'b1;
                    state_nx = ST_FETCH;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (redirect) begin
                pc <= bus.redirect_addr;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
        end
    end

    ifu_buf2 #(.AW(AW)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight && !flush),
        .pop       (xfer),
        .flush     (flush),
        .push_pc   (inflight_pc),
        .push_word (bus.imem_rdata),
        .head_pc   (head_pc),
        .head_word (head_word),
        .count     (count)
    );

    assign bus.imem_en   = issue;
    assign bus.imem_addr = issue ? pc : '0;
    assign bus.ir_valid  = valid;
    assign bus.ir_out    = valid ? head_word : '0;
    assign bus.ir_pc     = valid ? head_pc : '0;
    assign halted        = (state == ST_HALTED);

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (xfer && (perf_issued != '1)) perf_issued <= perf_issued + 1'b1;
            if (valid && !bus.ir_ready && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: per-cycle vector table, directed corner sequences and a
// random stream checked against a transaction-level model of the expected instruction order.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam int unsigned   AW       = 8;
    localparam logic [AW-1:0] RESET_PC = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic halted;
`ifdef IFU_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit_if #(.AW(AW)) bus ();

    instr_fetch_unit #(.AW(AW), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .halted (halted)
`ifdef IFU_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

    int n_vec = 0;
    int n_miss = 0;

    // Transaction-level model: which instruction the consumer must see next.
    bit            m_active;
    bit            m_halted;
    logic [AW-1:0] exp_pc;
    int            gap;
    bit            stall_prev;
    logic [31:0]   prev_out;
    logic [AW-1:0] prev_pc;
    int            n_xfer;
    int            n_stall;
    int            en_cnt;
    logic [31:0]   smp_out;
    logic [AW-1:0] seen[$];

    typedef struct {
        logic        start;
        logic        ready;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic        en;
        logic [7:0]  addr;
        logic        valid;
        logic [7:0]  pc;
        logic [31:0] out;
        logic        hlt;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_halted = 1'b0; exp_pc = RESET_PC; gap = 0;
        stall_prev = 1'b0; n_xfer = 0; n_stall = 0; en_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0;
        bus.ir_ready = 1'b0; bus.redirect_en = 1'b0; bus.redirect_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cycle();
        logic        xfer;
        logic [31:0] want;
        @(negedge clk);
        smp_out = bus.ir_out;
        if (bus.imem_en) en_cnt++;
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        if (!m_active || m_halted) begin
            chk("quiet_en", {31'b0, bus.imem_en}, 32'd0);
            chk("quiet_valid", {31'b0, bus.ir_valid}, 32'd0);
        end else begin
            chk("valid", {31'b0, bus.ir_valid}, {31'b0, gap >= 2});
        end
        if (stall_prev) begin
            chk("hold_out", bus.ir_out, prev_out);
            chk("hold_pc", {24'b0, bus.ir_pc}, {24'b0, prev_pc});
        end
        xfer = bus.ir_valid && bus.ir_ready;
        want = mem[exp_pc];
        if (xfer) begin
            chk("xfer_pc", {24'b0, bus.ir_pc}, {24'b0, exp_pc});
            chk("xfer_word", bus.ir_out, want);
            seen.push_back(bus.ir_pc);
            n_xfer++;
            exp_pc = exp_pc + 8'd1;
        end
        if (bus.ir_valid && !bus.ir_ready) n_stall++;
        stall_prev = bus.ir_valid && !bus.ir_ready && !bus.redirect_en;
        prev_out = bus.ir_out;
        prev_pc  = bus.ir_pc;
        if (m_active && bus.redirect_en) begin
            exp_pc = bus.redirect_addr; m_halted = 1'b0; gap = 0;
        end else if (xfer && (want[31:27] == OP_HALT)) begin
            m_halted = 1'b1; gap = 0;
        end else if (!m_active && start) begin
            m_active = 1'b1; exp_pc = RESET_PC; gap = 0;
        end else if (gap < 1000) begin
            gap++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_directed_mem();
        for (int i = 0; i < 256; i++) mem[i] = {OP_MOV, i[26:0]};
        mem[0] = 32'h1000_0000;
        mem[1] = 32'h1100_0000;
        mem[2] = 32'h1200_0000;
        mem[3] = 32'hF800_0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        logic [31:0] w;
        load_directed_mem();
        bus.ir_ready = 1'b0; bus.redirect_en = 1'b0; bus.redirect_addr = '0;

        // Reset values
        @(posedge clk); #1;
        chk("rst_en", {31'b0, bus.imem_en}, 32'd0);
        chk("rst_addr", {24'b0, bus.imem_addr}, 32'd0);
        chk("rst_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("rst_out", bus.ir_out, 32'd0);
        chk("rst_pc", {24'b0, bus.ir_pc}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        do_reset();

        // Stream to HALT, ignored start, redirect out of HALTED
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 32'h0,         1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 32'h0,         1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00, 32'h1000_0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h01, 32'h1100_0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h02, 32'h1200_0000, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h03, 32'hF800_0000, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,         1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,         1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 8'h00, 32'h0,         1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 8'h00, 32'h0,         1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 8'h10, 32'h0800_0010, 1'b0};
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start;
            bus.ir_ready = tbl[i].ready;
            bus.redirect_en = tbl[i].rd_en;
            bus.redirect_addr = tbl[i].rd_addr;
            @(negedge clk);
            chk("tbl_en", {31'b0, bus.imem_en}, {31'b0, tbl[i].en});
            chk("tbl_addr", {24'b0, bus.imem_addr}, {24'b0, tbl[i].addr});
            chk("tbl_valid", {31'b0, bus.ir_valid}, {31'b0, tbl[i].valid});
            chk("tbl_halted", {31'b0, halted}, {31'b0, tbl[i].hlt});
            if (tbl[i].valid) begin
                chk("tbl_pc", {24'b0, bus.ir_pc}, {24'b0, tbl[i].pc});
                chk("tbl_out", bus.ir_out, tbl[i].out);
            end
            @(posedge clk); #1;
        end

        // Backpressure from the first valid cycle
        do_reset();
        start = 1'b1; cycle(); start = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_out", smp_out, 32'h1000_0000);
        end
        chk("stall_reads", {31'b0, en_cnt <= 2}, 32'd1);
        bus.ir_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_xfers", n_xfer, 32'd4);

        // Redirect while two words are buffered
        do_reset();
        start = 1'b1; cycle(); start = 1'b0;
        repeat (3) cycle();
        seen.delete();
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'h40;
        cycle();
        bus.redirect_en = 1'b0; bus.ir_ready = 1'b1;
        repeat (10) cycle();
        chk("redir_first", (seen.size() > 0) ? {24'b0, seen[0]} : 32'hFFFF_FFFF, 32'h40);

        // PC wrap 0xFF -> 0x00, then HALT at 3
        seen.delete();
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'hFD;
        cycle();
        bus.redirect_en = 1'b0;
        repeat (12) cycle();
        found = 1'b0;
        for (int i = 0; i + 1 < seen.size(); i++)
            if (seen[i] == 8'hFF && seen[i+1] == 8'h00) found = 1'b1;
        chk("wrap", {31'b0, found}, 32'd1);

        // Reset mid-stream with a read in flight
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'h20;
        cycle();
        bus.redirect_en = 1'b0;
        repeat (6) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {31'b0, bus.imem_en}, 32'd0);
        chk("mid_rst_addr", {24'b0, bus.imem_addr}, 32'd0);
        chk("mid_rst_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("mid_rst_out", bus.ir_out, 32'd0);
        chk("mid_rst_pc", {24'b0, bus.ir_pc}, 32'd0);
        chk("mid_rst_halted", {31'b0, halted}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        repeat (5) cycle();
        start = 1'b1; cycle(); start = 1'b0;
        repeat (8) cycle();

        // Random program, ready, redirects and stray starts
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if ($urandom_range(0, 24) == 0) w[31:27] = OP_HALT;
            else if (w[31:27] == OP_HALT) w[31:27] = OP_ADD;
            mem[i] = w;
        end
        do_reset();
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.ir_ready = ($urandom_range(0, 9) < 7);
            bus.redirect_en = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
            bus.redirect_addr = 8'($urandom);
            start = ($urandom_range(0, 49) == 0);
            cycle();
        end
        bus.redirect_en = 1'b0; start = 1'b0;
`ifdef IFU_PERF_EN
        chk("perf_issued", perf_issued, n_xfer);
        chk("perf_stall", perf_stall, n_stall);
`endif
        chk("rand_progress", {31'b0, n_xfer > 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
